pixel_averager: RTL and testbench
=================================

# pixel_averager

Streaming front-end that feeds the MLP. Accepts a raster-order IMG_SIDE×IMG_SIDE grayscale image one pixel per handshake and averages each non-overlapping 2×2 block into one output feature. Publishes the flattened feature vector on `averaged_pixels` and pulses `MLP_go`. Holds the vector stable, with input back-pressured, until the MLP returns `MLP_done`.

## Interface
- `IMG_SIDE`, 28: image side in pixels; must be even.
- `WIDTH`, 8: pixel and feature bit width (unsigned).
- `averaged_pixels_nr`, (IMG_SIDE/2)², 196 by default: number of output features; derived, not overridden.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk`.
- `pix_valid`  in  1  upstream pixel valid.
- `pix_sof`  in  1  start-of-frame, qualified by `pix_valid`.
- `pix_data`  in  WIDTH  unsigned pixel value.
- `pix_ready`  out  1  block can accept a pixel; registered.
- `MLP_done`  in  1  one-cycle pulse from the MLP when computation finishes.
- `MLP_go`  out  1  one-cycle start pulse to the MLP.
- `averaged_pixels`  out  WIDTH*averaged_pixels_nr  feature k = (r/2)*(IMG_SIDE/2)+(c/2) at bits [WIDTH*k +: WIDTH]; k=0 at LSB.

## Operation
- Transfer: a pixel is accepted when `pix_valid && pix_ready` are both high in the same cycle; no other cycle changes counters.
- Counters:
  - column counter `c` runs 0..IMG_SIDE-1.
  - row counter `r` runs 0..IMG_SIDE-1.
  - `c` wraps to 0 and `r` increments after c=IMG_SIDE-1.
- Row buffer: IMG_SIDE/2 accumulators, WIDTH+2 bits each.
  - Even r, even c: acc[c/2] ← pix.
  - Even r, odd c: acc[c/2] += pix.
  - Odd r, even c: acc[c/2] += pix.
  - Odd r, odd c: sum = acc[c/2]+pix; feature[k] ← sum>>2 (see Configuration for rounding).
- The sum cannot overflow: max 4·(2^WIDTH−1) fits in WIDTH+2 bits, and the result always fits in WIDTH bits.
- Feature writes go directly into the `averaged_pixels` register. The vector may only change while the state is FILL.
- FSM states:
  - FILL: `pix_ready`=1. On acceptance of pixel (IMG_SIDE−1, IMG_SIDE−1), write the last feature and go to ISSUE.
  - ISSUE: one cycle. `MLP_go`=1, `pix_ready`=0, then go to WAIT.
  - WAIT: `pix_ready`=0. On `MLP_done`=1, clear counters and go to FILL.
- `pix_sof` accepted with a pixel forces that pixel to be treated as (0,0) and discards any partial frame. Features already written are overwritten as the new frame progresses.
- `pix_sof` on a pixel that is already (0,0) has no extra effect.
- `MLP_done` outside WAIT is ignored, including during ISSUE.
- Reset has priority over everything:
  - clears counters, accumulators and `averaged_pixels` to 0.
  - `MLP_go`=0, `pix_ready`=0, state → FILL.
  - Asserting reset in any state, including mid-frame, aborts that frame.

## Timing
- Reset values: `pix_ready`=0, `MLP_go`=0, `averaged_pixels`=0.
- `pix_ready` is 1 in the first cycle after `reset` is sampled high.
- Throughput: 1 pixel/cycle in FILL; a frame takes IMG_SIDE² accepting cycles.
- Latency from last-pixel acceptance (cycle N):
  - the final feature is visible at N+1.
  - `MLP_go`=1 during cycle N+1 only.
  - `pix_ready` falls at N+1.
- All features are stable from N+1 until the next frame's first feature write.
- `MLP_done` sampled at cycle M in WAIT → `pix_ready`=1 at M+1.
- Minimum gap between the last pixel of one frame and the first pixel of the next is 3 cycles (ISSUE, WAIT with `MLP_done`, then FILL).

## Configuration
- `PIXEL_AVG_ROUND_EN` defined: feature = (sum+2)>>2, i.e. round half up.
- `PIXEL_AVG_ROUND_EN` undefined: feature = sum>>2, i.e. truncate.
- No other behaviour differs between the two builds.

## Test plan
- Frame of all 8'd255 → at N+1 every feature = 8'hFF, `MLP_go` high for exactly 1 cycle, `pix_ready`=0; `MLP_done` pulse → `pix_ready`=1 next cycle.
- Block (0,0) pixels 1,2,3,4, rest 0:
  - truncate build: feature[0]=2.
  - `PIXEL_AVG_ROUND_EN` build: feature[0]=3.
  - in both builds, features 1..195 = 0.
- Ramp pix=(r*28+c)&8'hFF with `pix_valid` toggling every other cycle → every feature matches the reference model, and `MLP_go` fires only after the 784th accepted pixel.
- 300 pixels of 8'd100, then `pix_sof` with a full frame of 8'd10 → exactly one `MLP_go`, and all features = 10.
- In WAIT, hold `pix_valid`=1 with `pix_data`=8'd77 for 50 cycles → `pix_ready`=0, `averaged_pixels` unchanged; an `MLP_done` pulse during ISSUE is ignored, and a later pulse is honoured.
- `reset` low mid-frame (pixel 400) → next cycle `averaged_pixels`=0, `MLP_go`=0, `pix_ready`=0; after release, a full new frame produces correct features and a single `MLP_go`.

Source files
------------

// File: rtl/pixel_averager_if.sv
// pixel_averager_if
// Pixel stream handshake between an upstream raster source and pixel_averager.
//   pix_valid  upstream pixel valid
//   pix_sof    start-of-frame, qualified by pix_valid
//   pix_data   unsigned pixel value, WIDTH bits
//   pix_ready  sink can accept a pixel (driven by the sink, registered there)
// Modports: master = pixel source, slave = pixel_averager.
interface pixel_averager_if #(
    parameter int WIDTH = 8
) ();
    logic             pix_valid;
    logic             pix_sof;
    logic [WIDTH-1:0] pix_data;
    logic             pix_ready;

    modport master (
        output pix_valid,
        output pix_sof,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_sof,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/pixel_averager.sv
// pixel_averager
// Streaming MLP front-end: takes a raster-order IMG_SIDE x IMG_SIDE grayscale
// image one pixel per handshake, averages every non-overlapping 2x2 block into
// one feature, publishes the flattened vector and pulses MLP_go. The vector is
// held stable and input is back-pressured until MLP_done returns.
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous, active-low
//   pix              pixel stream (pixel_averager_if.slave)
//   MLP_done         one-cycle completion pulse from the MLP
//   MLP_go           one-cycle start pulse to the MLP
//   averaged_pixels  feature k = (r/2)*(IMG_SIDE/2)+(c/2) at [WIDTH*k +: WIDTH]
//
// Build option: define PIXEL_AVG_ROUND_EN for round-half-up averaging
// ((sum+2)>>2); otherwise the average truncates (sum>>2).
//
// state  | meaning
// -------+-------------------------------------------------------------
// FILL   | accepting pixels, accumulating blocks, writing features
// ISSUE  | one cycle, MLP_go high, input blocked
// WAIT   | input blocked, vector held until MLP_done
module pixel_averager #(
    parameter  int IMG_SIDE           = 28,
    parameter  int WIDTH              = 8,
    localparam int averaged_pixels_nr = (IMG_SIDE / 2) * (IMG_SIDE / 2)
) (
    input  logic                                clk,
    input  logic                                reset,
    pixel_averager_if.slave                     pix,
    input  logic                                MLP_done,
    output logic                                MLP_go,
    output logic [WIDTH*averaged_pixels_nr-1:0] averaged_pixels
);
    localparam int HALF = IMG_SIDE / 2;
    localparam int CW   = $clog2(IMG_SIDE);
    localparam int AW   = WIDTH + 2;
    localparam int FW   = WIDTH * averaged_pixels_nr;
    localparam logic [CW-1:0] LAST = CW'(IMG_SIDE - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             c_q, c_d;
    logic [CW-1:0]             r_q, r_d;
    logic [HALF-1:0][AW-1:0]   acc_q, acc_d;
    logic [FW-1:0]             feat_q, feat_d;
    logic                      ready_q, ready_d;

    logic                      accept;
    logic [CW-1:0]             col_eff;
    logic [CW-1:0]             row_eff;
    logic [CW-2:0]             idx;
    logic [AW-1:0]             sum;
    logic [AW-1:0]             sum_rnd;
    logic [WIDTH-1:0]          feat_val;
    int                        feat_idx;

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        r_d      = r_q;
        acc_d    = acc_q;
        feat_d   = feat_q;
        ready_d  = 1'b0;

        accept   = pix.pix_valid && ready_q;
        // A start-of-frame pixel is always position (0,0), discarding any partial frame.
        col_eff  = pix.pix_sof ? '0 : c_q;
        row_eff  = pix.pix_sof ? '0 : r_q;
        idx      = col_eff[CW-1:1];
        sum      = acc_q[idx] + AW'(pix.pix_data);
`ifdef PIXEL_AVG_ROUND_EN
        sum_rnd  = sum + AW'(2);
`else
        sum_rnd  = sum;
`endif
        // Max sum is 4*(2^WIDTH-1) (+2 when rounding), so the shifted value fits WIDTH bits.
        feat_val = WIDTH'(sum_rnd >> 2);
        feat_idx = int'(row_eff[CW-1:1]) * HALF + int'(idx);

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    case ({row_eff[0], col_eff[0]})
                        2'b00:   acc_d[idx] = AW'(pix.pix_data);
                        2'b01,
                        2'b10:   acc_d[idx] = sum;
                        default: feat_d[WIDTH*feat_idx +: WIDTH] = feat_val;
                    endcase

                    if (col_eff == LAST) begin
                        c_d = '0;
                        if (row_eff == LAST) begin
                            r_d     = '0;
                            state_d = S_ISSUE;
                        end else begin
                            r_d = row_eff + CW'(1);
                        end
                    end else begin
                        c_d = col_eff + CW'(1);
                        r_d = row_eff;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (MLP_done) begin
                    c_d     = '0;
                    r_d     = '0;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        // Registered ready follows the next state so it is valid in the cycle it applies.
        ready_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FILL;
            c_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            feat_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            feat_q  <= feat_d;
            ready_q <= ready_d;
        end
    end

    assign pix.pix_ready   = ready_q;
    assign MLP_go          = (state_q == S_ISSUE);
    assign averaged_pixels = feat_q;
endmodule

// File: tb/tb_pixel_averager.sv
module tb_pixel_averager;
    localparam int SIDE  = 28;
    localparam int W     = 8;
    localparam int HALF  = SIDE / 2;
    localparam int NFEAT = HALF * HALF;

    logic              clk = 1'b0;
    logic              reset;
    logic              MLP_done;
    logic              MLP_go;
    logic [W*NFEAT-1:0] averaged_pixels;

    pixel_averager_if #(.WIDTH(W)) pif ();

    pixel_averager #(
        .IMG_SIDE (SIDE),
        .WIDTH    (W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pix             (pif),
        .MLP_done        (MLP_done),
        .MLP_go          (MLP_go),
        .averaged_pixels (averaged_pixels)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int go_cnt   = 0;
    int go_base  = 0;
    logic [7:0] img [SIDE][SIDE];

    always @(negedge clk) if (MLP_go === 1'b1) go_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic logic [7:0] model_feat(input int k);
        int rr, cc, s;
        rr = (k / HALF) * 2;
        cc = (k % HALF) * 2;
        s  = int'(img[rr][cc]) + int'(img[rr][cc+1]) + int'(img[rr+1][cc]) + int'(img[rr+1][cc+1]);
`ifdef PIXEL_AVG_ROUND_EN
        s  = s + 2;
`endif
        return 8'(s >> 2);
    endfunction

    task automatic check_feats(input string tag);
        for (int k = 0; k < NFEAT; k++)
            check($sformatf("%s_f%0d", tag, k), 32'(averaged_pixels[W*k +: W]), 32'(model_feat(k)));
    endtask

    task automatic send_pix(input logic [7:0] d, input logic sof);
        int t;
        t = 0;
        pif.pix_valid = 1'b1;
        pif.pix_data  = d;
        pif.pix_sof   = sof;
        while (pif.pix_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (pif.pix_ready !== 1'b1) check("pix_accept_timeout", 32'(pif.pix_ready), 32'd1);
        @(posedge clk); #1;
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;
    endtask

    // Sends the first n pixels of img in raster order; returns #1 after the last accept edge.
    task automatic send_img(input int n, input int gap, input bit use_sof);
        go_base = go_cnt;
        for (int i = 0; i < n; i++) begin
            if (i == SIDE*SIDE-1) check("go_early", 32'(go_cnt), 32'(go_base));
            send_pix(img[i / SIDE][i % SIDE], use_sof && (i == 0));
            if (i < n-1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic after_frame(input string tag);
        check({tag, "_go"}, 32'(MLP_go), 32'd1);
        check({tag, "_ready"}, 32'(pif.pix_ready), 32'd0);
        check_feats(tag);
    endtask

    task automatic go_single(input string tag);
        @(posedge clk); #1;
        check({tag, "_go_low"}, 32'(MLP_go), 32'd0);
        check({tag, "_go_cnt"}, 32'(go_cnt), 32'(go_base + 1));
    endtask

    task automatic do_done(input string tag);
        MLP_done = 1'b1;
        @(posedge clk); #1;
        MLP_done = 1'b0;
        check({tag, "_done_ready"}, 32'(pif.pix_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b0;
        MLP_done      = 1'b0;
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;
        pif.pix_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(pif.pix_ready), 32'd0);
        check("rst_go", 32'(MLP_go), 32'd0);
        check("rst_vec", 32'(|averaged_pixels), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 32'(pif.pix_ready), 32'd1);

        // All-255 frame
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) img[r][c] = 8'd255;
        send_img(SIDE*SIDE, 0, 1'b1);
        after_frame("f255");
        check("f255_f0_hex", 32'(averaged_pixels[7:0]), 32'hFF);
        go_single("f255");
        repeat (3) begin @(posedge clk); #1; end
        check("f255_wait_ready", 32'(pif.pix_ready), 32'd0);
        do_done("f255");

        // Single block 1,2,3,4, rest zero
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) img[r][c] = 8'd0;
        img[0][0] = 8'd1; img[0][1] = 8'd2; img[1][0] = 8'd3; img[1][1] = 8'd4;
        send_img(SIDE*SIDE, 0, 1'b0);
        after_frame("blk");
`ifdef PIXEL_AVG_ROUND_EN
        check("blk_f0_const", 32'(averaged_pixels[7:0]), 32'd3);
`else
        check("blk_f0_const", 32'(averaged_pixels[7:0]), 32'd2);
`endif
        go_single("blk");
        do_done("blk");

        // Ramp with valid every other cycle
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) img[r][c] = 8'((r*SIDE + c) & 8'hFF);
        send_img(SIDE*SIDE, 1, 1'b1);
        after_frame("ramp");
        go_single("ramp");
        do_done("ramp");

        // Partial frame of 100, then sof with a full frame of 10
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) img[r][c] = 8'd100;
        send_img(300, 0, 1'b1);
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) img[r][c] = 8'd10;
        begin
            int base_outer;
            base_outer = go_cnt;
            send_img(SIDE*SIDE, 0, 1'b1);
            go_base = base_outer;
        end
        after_frame("sof");
        // MLP_done during ISSUE must be ignored
        MLP_done = 1'b1;
        @(posedge clk); #1;
        MLP_done = 1'b0;
        check("sof_go_low", 32'(MLP_go), 32'd0);
        check("sof_go_cnt", 32'(go_cnt), 32'(go_base + 1));
        check("issue_done_ignored", 32'(pif.pix_ready), 32'd0);
        // Hold valid in WAIT
        pif.pix_valid = 1'b1;
        pif.pix_data  = 8'd77;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check($sformatf("wait_ready_%0d", i), 32'(pif.pix_ready), 32'd0);
        end
        pif.pix_valid = 1'b0;
        check_feats("wait_hold");
        check("wait_go_cnt", 32'(go_cnt), 32'(go_base + 1));
        do_done("wait");

        // Reset mid-frame after pixel 400
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) img[r][c] = 8'((r*SIDE + c) & 8'hFF);
        send_img(400, 0, 1'b1);
        begin
            int base_rst;
            base_rst = go_cnt;
            reset = 1'b0;
            @(posedge clk); #1;
            check("mid_rst_vec", 32'(|averaged_pixels), 32'd0);
            check("mid_rst_go", 32'(MLP_go), 32'd0);
            check("mid_rst_ready", 32'(pif.pix_ready), 32'd0);
            reset = 1'b1;
            @(posedge clk); #1;
            check("mid_rel_ready", 32'(pif.pix_ready), 32'd1);
            check("mid_rst_go_cnt", 32'(go_cnt), 32'(base_rst));
        end
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) img[r][c] = 8'((r*5 + c*9) & 8'hFF);
        send_img(SIDE*SIDE, 0, 1'b0);
        after_frame("post_rst");
        go_single("post_rst");
        do_done("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
